// File: rtl/vaddsub_seq.sv
// vaddsub_seq
//   Sequencer for a vector add/subtract instruction. It walks the beats of one
//   instruction: it reads the two source registers, drives a shared external
//   segmented adder, and issues one write-back per beat.
//
// Ports
//   clk, reset_n            clock; asynchronous active-low reset
//   in_valid/in_ready       instruction handshake
//   in_op                   0 = add, 1 = subtract
//   in_sew                  element width: 00 = 8, 01 = 16, 10 = 32, 11 = illegal
//   in_lmul                 beat count: 00 = 1, 01 = 2, 10 = 4, 11 = 8
//   in_vs1/in_vs2/in_vd     base register numbers
//   rd_addr_a/b, rd_data_a/b register-file read ports (combinational data)
//   add_ctrl, add_sew_16_32, add_sew_32, add_a, add_b, add_sum
//                           shared segmented adder interface
//   wb_valid/wb_ready, wb_addr, wb_data
//                           write-back handshake
//   busy, done, error       status; done and error are one-cycle pulses
module vaddsub_seq #(
    parameter int WIDTH = 512
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_op,
    input  logic [1:0]       in_sew,
    input  logic [1:0]       in_lmul,
    input  logic [4:0]       in_vs1,
    input  logic [4:0]       in_vs2,
    input  logic [4:0]       in_vd,
    output logic [4:0]       rd_addr_a,
    output logic [4:0]       rd_addr_b,
    input  logic [WIDTH-1:0] rd_data_a,
    input  logic [WIDTH-1:0] rd_data_b,
    output logic             add_ctrl,
    output logic             add_sew_16_32,
    output logic             add_sew_32,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    input  logic [WIDTH-1:0] add_sum,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [4:0]       wb_addr,
    output logic [WIDTH-1:0] wb_data,
    output logic             busy,
    output logic             done,
    output logic             error
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             op_q;
    logic [1:0]       sew_q;
    logic [2:0]       last_q;     // beats - 1
    logic [4:0]       vs1_q, vs2_q, vd_q;
    logic [2:0]       k_q;
    logic [WIDTH-1:0] wb_data_q;
    logic [4:0]       wb_addr_q;
    logic             done_q, error_q;
    logic             accept;
    logic             legal;
    logic [2:0]       last_in;

    // No acceptance in the done cycle, so done is never hidden behind a new accept.
    assign in_ready = (state_q == IDLE) && !done_q;
    assign accept   = in_valid && in_ready;
    assign legal    = (in_sew != 2'b11);
    assign busy     = (state_q != IDLE);
    assign wb_valid = (state_q == WB);
    assign wb_data  = wb_data_q;
    assign wb_addr  = wb_addr_q;
    assign done     = done_q;
    assign error    = error_q;

    always_comb begin
        last_in = 3'd0;
        case (in_lmul)
            2'b00:   last_in = 3'd0;
            2'b01:   last_in = 3'd1;
            2'b10:   last_in = 3'd3;
            default: last_in = 3'd7;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept && legal) state_d = EXEC;
            EXEC: state_d = WB;
            WB:   if (wb_ready) state_d = (k_q == last_q) ? IDLE : EXEC;
            default: state_d = IDLE;
        endcase
    end

    // Adder and read ports are only live during EXEC; zero otherwise.
    always_comb begin
        rd_addr_a     = '0;
        rd_addr_b     = '0;
        add_a         = '0;
        add_b         = '0;
        add_ctrl      = 1'b0;
        add_sew_16_32 = 1'b0;
        add_sew_32    = 1'b0;
        if (state_q == EXEC) begin
            rd_addr_a     = vs1_q + {2'b00, k_q};
            rd_addr_b     = vs2_q + {2'b00, k_q};
            add_a         = rd_data_a;
            add_b         = rd_data_b;
            add_ctrl      = op_q;
            add_sew_16_32 = (sew_q != 2'b00);
            add_sew_32    = (sew_q == 2'b10);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            op_q      <= 1'b0;
            sew_q     <= '0;
            last_q    <= '0;
            vs1_q     <= '0;
            vs2_q     <= '0;
            vd_q      <= '0;
            k_q       <= '0;
            wb_data_q <= '0;
            wb_addr_q <= '0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (legal) begin
                            op_q   <= in_op;
                            sew_q  <= in_sew;
                            last_q <= last_in;
                            vs1_q  <= in_vs1;
                            vs2_q  <= in_vs2;
                            vd_q   <= in_vd;
                            k_q    <= '0;
                        end else begin
                            error_q <= 1'b1;
                        end
                    end
                end
                EXEC: begin
                    wb_data_q <= add_sum;
                    wb_addr_q <= vd_q + {2'b00, k_q};
                end
                WB: begin
                    if (wb_ready) begin
                        if (k_q == last_q) begin
                            done_q <= 1'b1;
                        end else begin
                            k_q <= k_q + 3'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vaddsub_seq.sv
// tb_vaddsub_seq
//   Bench for vaddsub_seq. Provides a 32-entry register file and a byte-ripple
//   model of the shared segmented adder. Expected write-backs are computed from
//   register contents with plain per-lane arithmetic and queued at acceptance.
module tb_vaddsub_seq;

    localparam int W = 512;

    typedef struct {
        logic [4:0]   addr;
        logic [W-1:0] data;
    } sb_entry_t;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         in_valid, in_ready, in_op;
    logic [1:0]   in_sew, in_lmul;
    logic [4:0]   in_vs1, in_vs2, in_vd;
    logic [4:0]   rd_addr_a, rd_addr_b;
    logic [W-1:0] rd_data_a, rd_data_b;
    logic         add_ctrl, add_sew_16_32, add_sew_32;
    logic [W-1:0] add_a, add_b, add_sum;
    logic         wb_valid, wb_ready;
    logic [4:0]   wb_addr;
    logic [W-1:0] wb_data;
    logic         busy, done, error;

    logic [W-1:0] rf [32];
    sb_entry_t    sb [$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int hs_count = 0;
    int done_count = 0;
    int last_hs_cyc = 0;
    int last_done_cyc = 0;
    int acc_cyc = 0;
    logic [W-1:0] last_wb_data;
    logic [4:0]   last_wb_addr;
    logic         prev_stall;
    logic [W-1:0] prev_data;
    logic [4:0]   prev_addr;

    vaddsub_seq #(.WIDTH(W)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_sew(in_sew), .in_lmul(in_lmul),
        .in_vs1(in_vs1), .in_vs2(in_vs2), .in_vd(in_vd),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .add_ctrl(add_ctrl), .add_sew_16_32(add_sew_16_32), .add_sew_32(add_sew_32),
        .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign rd_data_a = rf[rd_addr_a];
    assign rd_data_b = rf[rd_addr_b];

    // Segmented adder: byte ripple, carry restarted at each lane boundary.
    function automatic logic [W-1:0] seg_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic sub, input logic s16, input logic s32);
        int unsigned ew;
        logic        c;
        logic [8:0]  s;
        logic [W-1:0] r;
        ew = s16 ? (s32 ? 32 : 16) : 8;
        c = 1'b0;
        r = '0;
        for (int unsigned i = 0; i < W / 8; i++) begin
            if (((i * 8) % ew) == 0) c = sub;
            s = {1'b0, a[8*i +: 8]} + {1'b0, b[8*i +: 8] ^ {8{sub}}} + {8'b0, c};
            r[8*i +: 8] = s[7:0];
            c = s[8];
        end
        return r;
    endfunction

    always_comb add_sum = seg_add(add_a, add_b, add_ctrl, add_sew_16_32, add_sew_32);

    // Reference result: direct per-lane arithmetic.
    function automatic logic [W-1:0] lane_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic sub, input logic [1:0] sew);
        logic [W-1:0] r;
        logic [31:0]  x, y, z;
        r = '0;
        for (int unsigned j = 0; j < W / 32; j++) begin
            x = a[32*j +: 32];
            y = b[32*j +: 32];
            z = '0;
            case (sew)
                2'b00: for (int unsigned l = 0; l < 4; l++)
                           z[8*l +: 8] = sub ? x[8*l +: 8] - y[8*l +: 8] : x[8*l +: 8] + y[8*l +: 8];
                2'b01: for (int unsigned l = 0; l < 2; l++)
                           z[16*l +: 16] = sub ? x[16*l +: 16] - y[16*l +: 16] : x[16*l +: 16] + y[16*l +: 16];
                default: z = sub ? x - y : x + y;
            endcase
            r[32*j +: 32] = z;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Protocol monitor and scoreboard consumer.
    always @(negedge clk) begin
        sb_entry_t e;
        if (!reset_n) begin
            prev_stall = 1'b0;
        end else begin
            chk("in_ready_rule", in_ready, !busy && !done);
            if (!(busy && !wb_valid)) begin
                chk("idle_add_a", add_a, '0);
                chk("idle_add_b", add_b, '0);
                chk("idle_ctrl", {add_ctrl, add_sew_16_32, add_sew_32, rd_addr_a, rd_addr_b}, '0);
            end
            if (prev_stall) begin
                chk("stall_valid", wb_valid, 1'b1);
                chk("stall_data", wb_data, prev_data);
                chk("stall_addr", wb_addr, prev_addr);
            end
            if (wb_valid && wb_ready) begin
                if (sb.size() == 0) begin
                    chk("wb_unexpected", wb_valid, 1'b0);
                end else begin
                    e = sb.pop_front();
                    chk("wb_addr", wb_addr, e.addr);
                    chk("wb_data", wb_data, e.data);
                end
                hs_count++;
                last_hs_cyc  = cyc;
                last_wb_data = wb_data;
                last_wb_addr = wb_addr;
            end
            if (done) begin
                chk("done_sb_empty", sb.size(), 0);
                done_count++;
                last_done_cyc = cyc;
            end
            prev_stall = wb_valid && !wb_ready;
            prev_data  = wb_data;
            prev_addr  = wb_addr;
        end
    end

    // Offer an instruction (called at a negedge); returns at the negedge after acceptance.
    task automatic issue(input logic op, input logic [1:0] sew, input logic [1:0] lmul,
                         input logic [4:0] vs1, input logic [4:0] vs2, input logic [4:0] vd,
                         input bit hold);
        int n;
        int unsigned nb;
        sb_entry_t e;
        in_op = op; in_sew = sew; in_lmul = lmul;
        in_vs1 = vs1; in_vs2 = vs2; in_vd = vd;
        in_valid = 1'b1;
        n = 0;
        while (in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", n < 100, 1'b1);
        acc_cyc = cyc + 1;
        nb = 1 << lmul;
        if (sew != 2'b11) begin
            for (int unsigned b = 0; b < nb; b++) begin
                e.addr = vd + 5'(b);
                e.data = lane_ref(rf[5'(vs1 + 5'(b))], rf[5'(vs2 + 5'(b))], op, sew);
                sb.push_back(e);
            end
        end
        @(posedge clk);
        @(negedge clk);
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (done !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("done_wait", n < 300, 1'b1);
        #1;
    endtask

    initial begin
        int h0;
        int d0;
        reset_n = 1'b0;
        in_valid = 1'b0; in_op = 1'b0; in_sew = '0; in_lmul = '0;
        in_vs1 = '0; in_vs2 = '0; in_vd = '0;
        wb_ready = 1'b1;
        for (int i = 0; i < 32; i++)
            for (int j = 0; j < W / 32; j++)
                rf[i][32*j +: 32] = $urandom;
        rf[1] = {16{32'hF7F7F7F7}};
        rf[2] = {16{32'h12121212}};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_status", {busy, done, error, wb_valid}, '0);
        chk("rst_wb_data", wb_data, '0);
        chk("rst_wb_addr", wb_addr, '0);
        chk("rst_add_a", add_a, '0);
        reset_n = 1'b1;
        @(negedge clk);

        // Add, sew=8, one beat: latency and known constant
        h0 = hs_count;
        issue(1'b0, 2'b00, 2'b00, 5'd1, 5'd2, 5'd3, 1'b0);
        wait_done();
        chk("t1_hs_count", hs_count - h0, 1);
        chk("t1_wb_cycle", last_hs_cyc, acc_cyc + 1);
        chk("t1_done_cycle", last_done_cyc, acc_cyc + 2);
        chk("t1_data", last_wb_data, {16{32'h09090909}});
        chk("t1_addr", last_wb_addr, 5'd3);

        // Subtract, sew=32, four beats with register wrap
        h0 = hs_count;
        issue(1'b1, 2'b10, 2'b10, 5'd30, 5'd4, 5'd29, 1'b0);
        wait_done();
        chk("t2_hs_count", hs_count - h0, 4);
        chk("t2_last_addr", last_wb_addr, 5'd0);

        // sew=16, two beats, first write-back stalled 5 cycles
        h0 = hs_count;
        wb_ready = 1'b0;
        issue(1'b0, 2'b01, 2'b01, 5'd10, 5'd11, 5'd12, 1'b0);
        repeat (5) @(negedge clk);
        chk("t3_stall_valid", wb_valid, 1'b1);
        chk("t3_stall_addr", wb_addr, 5'd12);
        chk("t3_stall_hs", hs_count - h0, 0);
        wb_ready = 1'b1;
        wait_done();
        chk("t3_hs_count", hs_count - h0, 2);

        // Illegal sew
        h0 = hs_count;
        @(negedge clk);
        issue(1'b0, 2'b11, 2'b00, 5'd1, 5'd2, 5'd3, 1'b0);
        chk("t4_error", error, 1'b1);
        chk("t4_no_wb", {wb_valid, busy}, '0);
        @(negedge clk);
        chk("t4_error_pulse", error, 1'b0);
        chk("t4_in_ready", in_ready, 1'b1);
        repeat (3) @(negedge clk);
        chk("t4_hs_count", hs_count - h0, 0);

        // Reset during the write-back of beat 2 of an eight-beat instruction
        h0 = hs_count;
        d0 = done_count;
        issue(1'b0, 2'b00, 2'b11, 5'd5, 5'd6, 5'd7, 1'b0);
        begin
            int n;
            n = 0;
            while (!(hs_count == h0 + 2 && wb_valid === 1'b1) && n < 50) begin
                @(negedge clk);
                #1;
                n++;
            end
            chk("t5_reach_beat2", n < 50, 1'b1);
        end
        reset_n = 1'b0;
        #1;
        chk("t5_wb_valid", wb_valid, 1'b0);
        chk("t5_in_ready", in_ready, 1'b1);
        chk("t5_status", {busy, done}, '0);
        chk("t5_wb_data", wb_data, '0);
        chk("t5_rd_addr", {rd_addr_a, rd_addr_b}, '0);
        sb.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("t5_no_done", done_count - d0, 0);
        h0 = hs_count;
        issue(1'b1, 2'b01, 2'b00, 5'd15, 5'd16, 5'd17, 1'b0);
        wait_done();
        chk("t5_after_hs", hs_count - h0, 1);

        // Back-to-back with in_valid held and fields changed while busy
        h0 = hs_count;
        @(negedge clk);
        issue(1'b0, 2'b00, 2'b01, 5'd8, 5'd9, 5'd14, 1'b1);
        in_op = 1'b1; in_sew = 2'b10; in_lmul = 2'b00;
        in_vs1 = 5'd20; in_vs2 = 5'd21; in_vd = 5'd22;
        chk("t6_busy_not_ready", in_ready, 1'b0);
        wait_done();
        chk("t6_first_hs", hs_count - h0, 2);
        d0 = last_done_cyc;
        issue(1'b1, 2'b10, 2'b00, 5'd20, 5'd21, 5'd22, 1'b0);
        chk("t6_accept_cycle", acc_cyc, d0 + 2);
        wait_done();
        chk("t6_second_hs", hs_count - h0, 3);
        chk("t6_addr", last_wb_addr, 5'd22);

        repeat (2) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
